vram_arbiter: RTL and testbench

Single-port video-RAM arbiter for the Game-of-Life display path. It shares one synchronous-read cell RAM between two requesters. The VGA scanout port reads the cell under the beam and has priority. The CPU port reads and writes cells through a valid/ack handshake and may stall. The block sits between the VGA timing generator (`disp_addr` = cell index col + row·20) and the 20×15-cell framebuffer RAM.

---
 rtl/vram_arbiter.sv | 100 ++++++++++
 tb/tb_vram_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Shares one synchronous-read cell RAM between VGA scanout (priority, refetch on address change)
// and a stallable CPU read/write port; all RAM and requester outputs are registered.
module vram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int CELLS  = 300
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, D1, D2, C1, C2, ACK} state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS);

  state_t            state;
  logic [ADDR_W-1:0] disp_tag;
  logic              disp_valid;
  logic              disp_miss;
  logic              cpu_oob;

  assign disp_miss = !disp_valid || (disp_addr != disp_tag);
  assign cpu_oob   = cpu_addr >= LAST_CELL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      disp_tag   <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (disp_miss) begin
            mem_addr   <= disp_addr;
            mem_we     <= 1'b0;
            disp_tag   <= disp_addr;
            disp_valid <= 1'b1;
            state      <= D1;
          end else if (cpu_req && cpu_oob) begin
            // Out-of-range addresses never reach the RAM.
            cpu_ack   <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
            state     <= ACK;
          end else if (cpu_req && cpu_we) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_we    <= 1'b1;
            cpu_ack   <= 1'b1;
            state     <= ACK;
          end else if (cpu_req) begin
            mem_addr <= cpu_addr;
            state    <= C1;
          end
        end
        D1: state <= D2;
        D2: begin
          disp_data <= mem_rdata;
          state     <= IDLE;
        end
        C1: state <= C2;
        C2: begin
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
          cpu_err   <= 1'b0;
          state     <= ACK;
        end
        ACK: begin
          // Request is still held here; ignoring it prevents a double issue.
          cpu_ack <= 1'b0;
          cpu_err <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous-read RAM model and a CPU response scoreboard.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] disp_addr;
  logic [7:0]  disp_data;
  logic        cpu_req, cpu_we;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [7:0]  cpu_rdata;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:511];
  logic        init, bd_we;
  logic [8:0]  bd_addr;
  logic [7:0]  bd_data;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    logic       chk_rd;
  } exp_t;
  exp_t sbq[$];

  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .disp_addr(disp_addr), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < 512; k++) ram[k] <= 8'(k);
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_we) begin
      ram[mem_addr[8:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[8:0]];
  end

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] rdata, input logic err, input int lat, input logic chk_rd);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.chk_rd = chk_rd;
    sbq.push_back(e);
  endtask

  task automatic wait_ack(input string tag);
    int   n = 0;
    logic seen = 1'b0;
    exp_t e;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (cpu_ack === 1'b1) seen = 1'b1;
    end
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(e.lat));
        chk({tag, "_err"}, 32'(cpu_err), 32'(e.err));
        if (e.chk_rd) chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(e.rdata));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    disp_addr = 18'd5; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick();
    init = 1'b0;
    chk("rst_disp_data", 32'(disp_data), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_cpu_err", 32'(cpu_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // First display fetch after reset release.
    rst_n = 1'b1;
    tick();
    chk("fetch5_mem_addr", 32'(mem_addr), 32'd5);
    tick();
    chk("fetch5_disp_early", 32'(disp_data), 32'd0);
    tick();
    chk("fetch5_disp_data", 32'(disp_data), 32'd5);

    // A refetch would pick up the altered cell; a constant address must not refetch.
    bd_we = 1'b1; bd_addr = 9'd5; bd_data = 8'h55;
    tick();
    bd_we = 1'b0;
    repeat (8) tick();
    chk("no_refetch", 32'(disp_data), 32'd5);
    bd_we = 1'b1; bd_data = 8'd5;
    tick();
    bd_we = 1'b0;

    // Uncontended write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'd42; cpu_wdata = 8'hFF;
    push(8'h00, 1'b0, 1, 1'b0);
    wait_ack("wr42");
    chk("wr42_mem_we", 32'(mem_we), 32'd1);
    chk("wr42_mem_addr", 32'(mem_addr), 32'd42);
    chk("wr42_mem_wdata", 32'(mem_wdata), 32'hFF);
    cpu_req = 1'b0;
    tick();
    chk("wr42_mem_we_off", 32'(mem_we), 32'd0);
    chk("wr42_ack_off", 32'(cpu_ack), 32'd0);
    chk("wr42_ram", 32'(ram[42]), 32'hFF);

    // Uncontended read back.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'd42;
    push(8'hFF, 1'b0, 3, 1'b1);
    wait_ack("rd42");
    cpu_req = 1'b0;
    tick();
    chk("rd42_ack_off", 32'(cpu_ack), 32'd0);

    // Read and display change on the same edge: display goes first.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'd7; disp_addr = 18'd6;
    push(8'd7, 1'b0, 6, 1'b1);
    wait_ack("rd7_contended");
    chk("contended_disp_data", 32'(disp_data), 32'd6);
    cpu_req = 1'b0;
    tick();

    // Out-of-range accesses.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'd300;
    push(8'h00, 1'b1, 1, 1'b1);
    wait_ack("rd300");
    cpu_req = 1'b0;
    tick();
    chk("rd300_err_off", 32'(cpu_err), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h3FFFF; cpu_wdata = 8'hAA;
    push(8'h00, 1'b1, 1, 1'b1);
    wait_ack("wr3ffff");
    cpu_req = 1'b0;
    tick();
    chk("oob_ram_untouched", 32'(ram[511]), 32'hFF);

    // Reset during C1; the held request is reissued after release.
    bd_we = 1'b1; bd_addr = 9'd10; bd_data = 8'h3C;
    tick();
    bd_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'd10;
    tick();
    chk("c1_mem_addr", 32'(mem_addr), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_addr", 32'(mem_addr), 32'd0);
    chk("async_disp_data", 32'(disp_data), 32'd0);
    chk("async_cpu_ack", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_ack", 32'(cpu_ack), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_fetch_addr", 32'(mem_addr), 32'd6);
    push(8'h3C, 1'b0, 5, 1'b1);
    wait_ack("rd10_reissue");
    chk("post_rst_disp_data", 32'(disp_data), 32'd6);
    cpu_req = 1'b0;
    tick();

    chk("mem_we_total_cycles", 32'(we_cnt), 32'd1);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
